// File: rtl/fc_pkg.sv
// Shared types and width helpers for the FC weight fetch controller.
package fc_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fc_state_t;

  function automatic int addr_w(input int n, input int d);
    return $clog2(n * d);
  endfunction

  function automatic int nidx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int didx_w(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/fc_weight_skid.sv
// Two-entry synchronous FIFO holding tagged weight beats between the ROM and the stream output.
module fc_weight_skid #(
  parameter type beat_t = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_data,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] occ,
  output logic       full,
  output logic       empty
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      assert (!(pop && r_occ == 2'd0));
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) r_rd_ptr <= ~r_rd_ptr;
      // Push and pop together leave occupancy untouched, even when full.
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign occ   = r_occ;
  assign full  = (r_occ == 2'd2);
  assign empty = (r_occ == 2'd0);

endmodule

// File: rtl/fc_weight_fetch.sv
// Sweeps the FC weight ROM row-major, hides its 1-cycle read latency and streams tagged weights.
module fc_weight_fetch
  import fc_pkg::*;
#(
  parameter  int NEURON_NUM = 10,
  parameter  int WEIGHT_DIM = 100,
  parameter  int DATA_WIDTH = 8,
  localparam int ADDR_W     = addr_w(NEURON_NUM, WEIGHT_DIM),
  localparam int NIDX_W     = nidx_w(NEURON_NUM),
  localparam int DIDX_W     = didx_w(WEIGHT_DIM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [NIDX_W-1:0]     w_neuron,
  output logic [DIDX_W-1:0]     w_dim,
  output logic                  w_last_dim,
  output logic                  w_last
);

  localparam int TOTAL = NEURON_NUM * WEIGHT_DIM;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NIDX_W-1:0]     neuron;
    logic [DIDX_W-1:0]     dim;
    logic                  last_dim;
    logic                  last;
  } beat_t;

  fc_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [NIDX_W-1:0] r_neuron;
  logic [DIDX_W-1:0] r_dim;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;
  logic [NIDX_W-1:0] r_if_neuron;
  logic [DIDX_W-1:0] r_if_dim;
  logic              r_if_last_dim;
  logic              r_if_last;

  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_occ;
  logic              w_issue;
  logic              w_dim_wrap;
  logic              w_row_last;
  logic              w_last_addr;
  logic              w_drained;
  beat_t             w_push_beat;
  beat_t             w_head;

  assign w_pop       = !w_empty && w_ready;
  assign w_dim_wrap  = (r_dim == DIDX_W'(WEIGHT_DIM - 1));
  assign w_row_last  = (r_neuron == NIDX_W'(NEURON_NUM - 1));
  assign w_last_addr = (r_addr == ADDR_W'(TOTAL - 1));
  // Credit check: buffered + returning - leaving must leave room for one more read.
  assign w_issue     = (r_state == FETCH) &&
                       ((({1'b0, w_occ} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2);
  // Looks one edge ahead so done follows the final accepted beat without an idle cycle.
  assign w_drained   = !r_inflight && ((w_occ == 2'd0) || (w_occ == 2'd1 && w_pop));
  assign w_push_beat = {rom_data, r_if_neuron, r_if_dim, r_if_last_dim, r_if_last};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_neuron      <= '0;
      r_dim         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_inflight    <= 1'b0;
      r_if_neuron   <= '0;
      r_if_dim      <= '0;
      r_if_last_dim <= 1'b0;
      r_if_last     <= 1'b0;
    end else begin
      assert (!(r_inflight && w_full && !w_pop));
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_neuron   <= r_neuron;
        r_if_dim      <= r_dim;
        r_if_last_dim <= w_dim_wrap;
        r_if_last     <= w_dim_wrap && w_row_last;
        r_addr        <= r_addr + ADDR_W'(1);
        if (w_dim_wrap) begin
          r_dim    <= '0;
          r_neuron <= r_neuron + NIDX_W'(1);
        end else begin
          r_dim <= r_dim + DIDX_W'(1);
        end
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FETCH;
            r_busy   <= 1'b1;
            r_addr   <= '0;
            r_neuron <= '0;
            r_dim    <= '0;
          end
        end
        FETCH: begin
          if (w_issue && w_last_addr) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drained) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fc_weight_skid #(
    .beat_t(beat_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_inflight),
    .push_data (w_push_beat),
    .pop       (w_pop),
    .head      (w_head),
    .occ       (w_occ),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign rom_en     = w_issue;
  assign rom_addr   = r_addr;
  assign w_valid    = !w_empty;
  assign w_data     = w_head.data;
  assign w_neuron   = w_head.neuron;
  assign w_dim      = w_head.dim;
  assign w_last_dim = w_head.last_dim;
  assign w_last     = w_head.last;

endmodule
